// File: rtl/onehot_hit_tracker_pkg.sv
// Shared types for the one-hot hit tracker: clear-FSM states and the
// zero/one-hot/multi-hot classification of a decode word.
package hit_tracker_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      CLS_ZERO   = 2'd0,
      CLS_ONEHOT = 2'd1,
      CLS_MULTI  = 2'd2
   } cls_e;

endpackage

// File: rtl/onehot_hit_tracker_if.sv
// Signal bundle between the decode/fanout stage, the counter reader and the
// hit tracker. The tracker takes the slave modport.
interface onehot_hit_tracker_if #(
   parameter int FANOUT = 64,
   parameter int IDX_W  = $clog2(FANOUT),
   parameter int CNT_W  = 8
) ();
   logic [FANOUT-1:0] decIn;
   logic              clearReq;
   // Read handshake: rdReq is a single-cycle request with no ready; it is
   // accepted only while busy=0 and then answered by a one-cycle rdValid on
   // the next edge. Requests made while busy=1 are silently dropped.
   logic              rdReq;
   logic [IDX_W-1:0]  rdIdx;
   logic              rdValid;
   logic [CNT_W-1:0]  rdCount;
   logic [IDX_W-1:0]  lastIdx;
   logic              lastValid;
   logic              errMulti;
   logic              busy;
   logic              ovfFlag;
   logic [0:0]        stateDbg;

   modport master (
      output decIn, clearReq, rdReq, rdIdx,
      input  rdValid, rdCount, lastIdx, lastValid, errMulti, busy, ovfFlag,
             stateDbg
   );

   modport slave (
      input  decIn, clearReq, rdReq, rdIdx,
      output rdValid, rdCount, lastIdx, lastValid, errMulti, busy, ovfFlag,
             stateDbg
   );
endinterface

// File: rtl/onehot_hit_tracker_encode.sv
// Combinational one-hot to index encoder with zero/one-hot/multi-hot
// classification. The index is only meaningful when cls is CLS_ONEHOT.
module onehot_encode
   import hit_tracker_pkg::*;
#(
   parameter int FANOUT = 64,
   parameter int IDX_W  = $clog2(FANOUT)
) (
   input  logic [FANOUT-1:0] word,
   output logic [IDX_W-1:0]  idx,
   output cls_e              cls
);

   logic multi;

   // OR-reduction of set-bit positions; exact for a single set bit.
   always_comb begin
      idx = '0;
      for (int i = 0; i < FANOUT; i++) begin
         if (word[i]) idx = idx | IDX_W'(i);
      end
   end

   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi = |(word & (word - FANOUT'(1)));

   always_comb begin
      cls = CLS_ZERO;
      if (multi)      cls = CLS_MULTI;
      else if (|word) cls = CLS_ONEHOT;
   end

endmodule

// File: rtl/onehot_hit_tracker.sv
// Per-line hit counter behind a registered one-hot decode bus, with a swept
// clear and a read port. Define HIT_TRACKER_SATURATE_EN for saturating counters.
module onehot_hit_tracker
   import hit_tracker_pkg::*;
#(
   parameter int FANOUT = 64,
   parameter int IDX_W  = $clog2(FANOUT),
   parameter int CNT_W  = 8
) (
   input logic                clk,
   input logic                resetN,
   onehot_hit_tracker_if.slave bus
);

   localparam logic [0:0]       IDLE     = ST_IDLE;
   localparam logic [0:0]       CLEAR    = ST_CLEAR;
   localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(FANOUT - 1);

   logic [IDX_W-1:0] enc_idx;
   cls_e             enc_cls;

   onehot_encode #(.FANOUT(FANOUT), .IDX_W(IDX_W)) u_encode (
      .word (bus.decIn),
      .idx  (enc_idx),
      .cls  (enc_cls)
   );

   // Stage 1: classify and capture the encoded hit.
   logic [IDX_W-1:0] last_idx_q;
   logic             last_valid_q;
   logic             err_multi_q;

   always_ff @(posedge clk) begin
      if (!resetN) begin
         last_idx_q   <= '0;
         last_valid_q <= 1'b0;
         err_multi_q  <= 1'b0;
      end else begin
         last_valid_q <= (enc_cls == CLS_ONEHOT);
         if (enc_cls == CLS_ONEHOT) last_idx_q  <= enc_idx;
         if (enc_cls == CLS_MULTI)  err_multi_q <= 1'b1;
      end
   end

   logic [0:0]       state_q;
   logic [IDX_W-1:0] clr_ptr_q;
   logic             busy_q;
   logic             is_idle;

   assign is_idle = (state_q == IDLE);

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q   <= IDLE;
         clr_ptr_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.clearReq) begin
                  state_q   <= CLEAR;
                  clr_ptr_q <= '0;
                  busy_q    <= 1'b1;
               end
            end
            CLEAR: begin
               clr_ptr_q <= clr_ptr_q + IDX_W'(1);
               if (clr_ptr_q == LAST_PTR) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Stage 2: commit the captured hit unless the sweep owns the array.
   logic [CNT_W-1:0] cnt_q [FANOUT];
   logic [CNT_W-1:0] cur_cnt;
   logic [CNT_W-1:0] nxt_cnt;
   logic             inc_en;

   assign cur_cnt = cnt_q[last_idx_q];
   assign inc_en  = last_valid_q && is_idle;

`ifdef HIT_TRACKER_SATURATE_EN
   logic at_max;
   logic ovf_q;

   assign at_max  = (cur_cnt == {CNT_W{1'b1}});
   assign nxt_cnt = at_max ? cur_cnt : cur_cnt + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (!resetN)                ovf_q <= 1'b0;
      else if (inc_en && at_max)  ovf_q <= 1'b1;
   end

   assign bus.ovfFlag = ovf_q;
`else
   assign nxt_cnt     = cur_cnt + CNT_W'(1);
   assign bus.ovfFlag = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!resetN) begin
         for (int i = 0; i < FANOUT; i++) cnt_q[i] <= '0;
      end else if (!is_idle) begin
         cnt_q[clr_ptr_q] <= '0;
      end else if (inc_en) begin
         cnt_q[last_idx_q] <= nxt_cnt;
      end
   end

   // The read samples the array before this edge's increment lands.
   logic             rd_valid_q;
   logic [CNT_W-1:0] rd_count_q;

   always_ff @(posedge clk) begin
      if (!resetN) begin
         rd_valid_q <= 1'b0;
         rd_count_q <= '0;
      end else begin
         rd_valid_q <= bus.rdReq && is_idle;
         if (bus.rdReq && is_idle) rd_count_q <= cnt_q[bus.rdIdx];
      end
   end

   assign bus.rdValid   = rd_valid_q;
   assign bus.rdCount   = rd_count_q;
   assign bus.lastIdx   = last_idx_q;
   assign bus.lastValid = last_valid_q;
   assign bus.errMulti  = err_multi_q;
   assign bus.busy      = busy_q;
   assign bus.stateDbg  = state_q;

endmodule

// File: tb/tb_onehot_hit_tracker.sv
// Self-checking bench for onehot_hit_tracker: directed table, hand sequences
// for sweep/reset/read-collision corners, and a randomized run against a model.
module tb_onehot_hit_tracker;
   localparam int FANOUT = 64;
   localparam int IDX_W  = 6;
   localparam int CNT_W  = 8;
   localparam int MAXC   = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic resetN;
   always #5 clk = ~clk;

   onehot_hit_tracker_if #(.FANOUT(FANOUT), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

   onehot_hit_tracker #(.FANOUT(FANOUT), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int m_cnt [FANOUT];
   int m_pend;
   bit m_busy;
   int m_sweep_left;
   int m_sweep_next;
   bit m_last_valid;
   int m_last_idx;
   bit m_err;
   bit m_ovf;
   bit m_rd_valid;
   int m_rd_count;

   function automatic logic [FANOUT-1:0] oh(input int k);
      logic [FANOUT-1:0] one;
      one = 1;
      return one << k;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_pend = -1;
      m_busy = 0; m_sweep_left = 0; m_sweep_next = 0;
      m_last_valid = 0; m_last_idx = 0;
      m_err = 0; m_ovf = 0;
      m_rd_valid = 0; m_rd_count = 0;
   endtask

   // One clock edge of behaviour, all decisions taken from the pre-edge state.
   task automatic model_edge(input logic [FANOUT-1:0] dec, input bit clr, input bit rd, input int idx);
      bit was_busy;
      int ones;
      was_busy = m_busy;
      m_rd_valid = rd && !was_busy;
      if (m_rd_valid) m_rd_count = m_cnt[idx];
      if (m_pend >= 0 && !was_busy) begin
`ifdef HIT_TRACKER_SATURATE_EN
         if (m_cnt[m_pend] == MAXC) m_ovf = 1;
         else m_cnt[m_pend] = m_cnt[m_pend] + 1;
`else
         m_cnt[m_pend] = (m_cnt[m_pend] + 1) % (MAXC + 1);
`endif
      end
      if (was_busy) begin
         m_cnt[m_sweep_next] = 0;
         m_sweep_next++;
         m_sweep_left--;
         if (m_sweep_left == 0) m_busy = 0;
      end else if (clr) begin
         m_busy = 1;
         m_sweep_left = FANOUT;
         m_sweep_next = 0;
      end
      ones = $countones(dec);
      if (ones == 1) begin
         m_last_idx = $clog2(dec);
         m_last_valid = 1;
         m_pend = m_last_idx;
      end else begin
         m_last_valid = 0;
         m_pend = -1;
         if (ones > 1) m_err = 1;
      end
   endtask

   task automatic check_all();
      check("rdValid",   bus.rdValid,   m_rd_valid);
      check("rdCount",   bus.rdCount,   m_rd_count);
      check("lastValid", bus.lastValid, m_last_valid);
      check("lastIdx",   bus.lastIdx,   m_last_idx);
      check("errMulti",  bus.errMulti,  m_err);
      check("busy",      bus.busy,      m_busy);
      check("ovfFlag",   bus.ovfFlag,   m_ovf);
   endtask

   task automatic step(input logic [FANOUT-1:0] dec, input bit clr, input bit rd, input int idx);
      bus.decIn    = dec;
      bus.clearReq = clr;
      bus.rdReq    = rd;
      bus.rdIdx    = IDX_W'(idx);
      model_edge(dec, clr, rd, idx);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      resetN       = 1'b0;
      bus.decIn    = '0;
      bus.clearReq = 1'b0;
      bus.rdReq    = 1'b0;
      bus.rdIdx    = '0;
      @(posedge clk);
      #1;
      model_reset();
      check_all();
      resetN = 1'b1;
   endtask

   typedef struct {
      logic [FANOUT-1:0] dec;
      bit                rd;
      int                idx;
      bit                e_rd_valid;
      int                e_rd_count;
      bit                e_last_valid;
      int                e_last_idx;
      bit                e_err;
   } vec_t;

   vec_t vecs [9];
   int   busy_cnt;

   initial begin
      // Hit idx 5 three times, read it, then a multi-hot word and reads of 0/4.
      vecs[0] = '{oh(5),      0, 0, 0, 0, 1, 5, 0};
      vecs[1] = '{oh(5),      0, 0, 0, 0, 1, 5, 0};
      vecs[2] = '{oh(5),      0, 0, 0, 0, 1, 5, 0};
      vecs[3] = '{'0,         0, 0, 0, 0, 0, 5, 0};
      vecs[4] = '{'0,         1, 5, 1, 3, 0, 5, 0};
      vecs[5] = '{64'h11,     0, 0, 0, 3, 0, 5, 1};
      vecs[6] = '{'0,         1, 0, 1, 0, 0, 5, 1};
      vecs[7] = '{'0,         1, 4, 1, 0, 0, 5, 1};
      vecs[8] = '{'0,         0, 0, 0, 0, 0, 5, 1};

      model_reset();
      do_reset();
      check("rst_busy", bus.busy, 0);
      check("rst_state", bus.stateDbg, 0);

      foreach (vecs[i]) begin
         step(vecs[i].dec, 0, vecs[i].rd, vecs[i].idx);
         check($sformatf("vec%0d_rdValid", i),   bus.rdValid,   vecs[i].e_rd_valid);
         check($sformatf("vec%0d_rdCount", i),   bus.rdCount,   vecs[i].e_rd_count);
         check($sformatf("vec%0d_lastValid", i), bus.lastValid, vecs[i].e_last_valid);
         check($sformatf("vec%0d_lastIdx", i),   bus.lastIdx,   vecs[i].e_last_idx);
         check($sformatf("vec%0d_errMulti", i),  bus.errMulti,  vecs[i].e_err);
      end

      // 300 hits on the top line: wrap or saturate.
      for (int k = 0; k < 300; k++) step(oh(63), 0, 0, 0);
      step('0, 0, 0, 0);
      step('0, 0, 1, 63);
`ifdef HIT_TRACKER_SATURATE_EN
      check("ovf_rdCount", bus.rdCount, 255);
      check("ovf_flag",    bus.ovfFlag, 1);
`else
      check("wrap_rdCount", bus.rdCount, 44);
      check("wrap_ovf",     bus.ovfFlag, 0);
`endif

      // Sweep clear: busy for exactly FANOUT cycles, hits and reads dropped.
      do_reset();
      for (int k = 0; k < 2; k++) step(oh(1), 0, 0, 0);
      for (int k = 0; k < 7; k++) step(oh(9), 0, 0, 0);
      step('0, 0, 0, 0);
      step('0, 0, 1, 9);
      check("pre_clear_idx9", bus.rdCount, 7);
      step('0, 1, 1, 1);
      check("clr_read_pre", bus.rdCount, 2);
      busy_cnt = bus.busy;
      for (int k = 0; k < 200 && bus.busy; k++) begin
         step((k < 60) ? oh(1) : '0, 1, 1, 9);
         check("sweep_no_rd", bus.rdValid, 0);
         busy_cnt += bus.busy;
      end
      check("sweep_len", busy_cnt, FANOUT);
      step('0, 0, 0, 0);
      step('0, 0, 1, 1);
      check("post_clear_idx1", bus.rdCount, 0);
      step('0, 0, 1, 9);
      check("post_clear_idx9", bus.rdCount, 0);

      // Read colliding with the same-index commit returns the old count.
      do_reset();
      for (int k = 0; k < 4; k++) step(oh(7), 0, 0, 0);
      step('0, 0, 0, 0);
      step(oh(7), 0, 0, 0);
      step('0, 0, 1, 7);
      check("collide_rd", bus.rdCount, 4);
      step('0, 0, 1, 7);
      check("collide_after", bus.rdCount, 5);

      // Reset in the middle of a sweep, then a complete sweep.
      step(oh(3), 1, 0, 0);
      for (int k = 0; k < 10; k++) step('0, 0, 0, 0);
      check("mid_sweep_busy", bus.busy, 1);
      do_reset();
      check("abort_busy",  bus.busy, 0);
      check("abort_state", bus.stateDbg, 0);
      check("abort_rdv",   bus.rdValid, 0);
      step('0, 1, 0, 0);
      busy_cnt = bus.busy;
      for (int k = 0; k < 200 && bus.busy; k++) begin
         step('0, 0, 0, 0);
         busy_cnt += bus.busy;
      end
      check("resweep_len", busy_cnt, FANOUT);

      // Randomized traffic against the model.
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         logic [FANOUT-1:0] dec;
         int kind;
         kind = $urandom_range(0, 19);
         if (kind < 12)      dec = oh($urandom_range(0, 7));
         else if (kind < 15) dec = oh($urandom_range(0, FANOUT - 1));
         else if (kind < 19) dec = '0;
         else                dec = {$urandom, $urandom} | oh(2) | oh(40);
         step(dec, ($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0),
              $urandom_range(0, 7));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
